// File: rtl/addr_stream_reader.sv
// Address-driven memory reader: pulls addresses from a generator,
// issues reads under FIFO credit and streams the data out in order.
module addr_stream_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       total_count,
  output logic              step,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [15:0]       total_q;
  logic [15:0]       issued_q;
  logic [RD_LAT-1:0] vld_sr;
  logic [IW-1:0]     inflight;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic              issue;
  logic              push;
  logic              pop;
  logic              credit;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + IW'(vld_sr[i]);
  end

  // Credit counts words already buffered plus reads still in flight.
  assign credit = (32'(fifo_cnt) + 32'(inflight)) < FIFO_DEPTH;

  assign issue = (state == RUN)
              && (issued_q != total_q)
              && credit;

  assign step      = issue;
  assign mem_rd_en = issue;
  assign mem_addr  = addr_in;

  assign push      = vld_sr[RD_LAT-1];
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_mem[rd_ptr];
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = RUN;
      end
      RUN: begin
        if (issued_q == total_q)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0 && fifo_cnt == '0) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      total_q  <= '0;
      issued_q <= '0;
      vld_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        total_q  <= total_count;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 16'd1;
      end
      vld_sr <= RD_LAT'({vld_sr, issue});
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push)
      fifo_mem[wr_ptr] <= mem_rd_data;
  end

endmodule

// File: tb/tb_addr_stream_reader.sv
// Bench for addr_stream_reader: RD_LAT=1 and RD_LAT=3 instances
// share stimulus; words are checked against mem[a]=a+0x100.
module tb_addr_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] total_count;
  logic        out_ready;

  logic        step_a, rd_en_a, out_valid_a, busy_a, done_a;
  logic [15:0] addr_a, maddr_a, rdata_a, out_data_a;
  logic        step_b, rd_en_b, out_valid_b, busy_b, done_b;
  logic [15:0] addr_b, maddr_b, rdata_b, out_data_b;
  logic [15:0] pipe_b [3];

  logic        gen_load;
  logic [15:0] gen_base;
  logic [15:0] gen_stride;
  logic        mon_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addr_stream_reader #(
    .DATA_W(16), .ADDR_W(16), .FIFO_DEPTH(4), .RD_LAT(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .total_count(total_count), .step(step_a),
    .addr_in(addr_a), .mem_rd_en(rd_en_a),
    .mem_addr(maddr_a), .mem_rd_data(rdata_a),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .busy(busy_a), .done(done_a)
  );

  addr_stream_reader #(
    .DATA_W(16), .ADDR_W(16), .FIFO_DEPTH(4), .RD_LAT(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .total_count(total_count), .step(step_b),
    .addr_in(addr_b), .mem_rd_en(rd_en_b),
    .mem_addr(maddr_b), .mem_rd_data(rdata_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .busy(busy_b), .done(done_b)
  );

  // Memories: data only meaningful exactly RD_LAT cycles after a read.
  always @(posedge clk) begin
    rdata_a   <= rd_en_a ? maddr_a + 16'h100 : 16'($urandom);
    pipe_b[0] <= rd_en_b ? maddr_b + 16'h100 : 16'($urandom);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rdata_b = pipe_b[2];

  always @(posedge clk) begin
    if (gen_load) begin
      addr_a <= gen_base;
      addr_b <= gen_base;
    end else begin
      if (step_a) addr_a <= addr_a + gen_stride;
      if (step_b) addr_b <= addr_b + gen_stride;
    end
  end

  int steps_a, dones_a, got_n_a, outs_a, maxo_a, stab_a, badm_a, o_a;
  int steps_b, dones_b, got_n_b, outs_b, maxo_b, stab_b, badm_b, o_b;
  logic [15:0] got_a [64];
  logic [15:0] got_b [64];
  logic        hold_a, hold_b;
  logic [15:0] pd_a, pd_b;

  always @(posedge clk) begin
    if (mon_clr) begin
      steps_a <= 0; dones_a <= 0; got_n_a <= 0; outs_a <= 0;
      maxo_a <= 0; stab_a <= 0; badm_a <= 0; hold_a <= 1'b0;
    end else begin
      if (step_a) steps_a <= steps_a + 1;
      if (done_a) dones_a <= dones_a + 1;
      if (out_valid_a && out_ready) begin
        if (got_n_a < 64) got_a[got_n_a] <= out_data_a;
        got_n_a <= got_n_a + 1;
      end
      o_a = outs_a + int'(step_a) - int'(out_valid_a && out_ready);
      outs_a <= o_a;
      if (o_a > maxo_a) maxo_a <= o_a;
      if (hold_a && (!out_valid_a || out_data_a !== pd_a))
        stab_a <= stab_a + 1;
      if (step_a !== rd_en_a || (rd_en_a && maddr_a !== addr_a))
        badm_a <= badm_a + 1;
      hold_a <= out_valid_a && !out_ready;
      pd_a   <= out_data_a;
    end
  end

  always @(posedge clk) begin
    if (mon_clr) begin
      steps_b <= 0; dones_b <= 0; got_n_b <= 0; outs_b <= 0;
      maxo_b <= 0; stab_b <= 0; badm_b <= 0; hold_b <= 1'b0;
    end else begin
      if (step_b) steps_b <= steps_b + 1;
      if (done_b) dones_b <= dones_b + 1;
      if (out_valid_b && out_ready) begin
        if (got_n_b < 64) got_b[got_n_b] <= out_data_b;
        got_n_b <= got_n_b + 1;
      end
      o_b = outs_b + int'(step_b) - int'(out_valid_b && out_ready);
      outs_b <= o_b;
      if (o_b > maxo_b) maxo_b <= o_b;
      if (hold_b && (!out_valid_b || out_data_b !== pd_b))
        stab_b <= stab_b + 1;
      if (step_b !== rd_en_b || (rd_en_b && maddr_b !== addr_b))
        badm_b <= badm_b + 1;
      hold_b <= out_valid_b && !out_ready;
      pd_b   <= out_data_b;
    end
  end

  function automatic logic [15:0] exp_word(input int k);
    return gen_base + 16'(k) * gen_stride + 16'h100;
  endfunction

  task automatic start_xfer(input int n);
    @(negedge clk);
    mon_clr    = 1'b1;
    gen_load   = 1'b1;
    gen_base   = 16'($urandom);
    gen_stride = 16'($urandom_range(1, 9));
    @(negedge clk);
    mon_clr     = 1'b0;
    gen_load    = 1'b0;
    total_count = 16'(n);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_a && !busy_b) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [4:0] va, vb;
    rst_n = 1'b0; start = 1'b1; mon_clr = 1'b1;
    repeat (2) @(negedge clk);
    va = {step_a, rd_en_a, out_valid_a, busy_a, done_a};
    vb = {step_b, rd_en_b, out_valid_b, busy_b, done_b};
    checks++;
    if (va !== 5'b0) begin
      failures++;
      $display("FAIL reset_a outs=%b required=00000", va);
    end
    checks++;
    if (vb !== 5'b0) begin
      failures++;
      $display("FAIL reset_b outs=%b required=00000", vb);
    end
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_clr = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL post_reset busy=%b valid=%b required=0 0",
               busy_a, out_valid_a);
    end
  endtask

  task automatic test_basic;
    bit to;
    out_ready = 1'b1;
    start_xfer(6);
    wait_idle(100, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL basic_timeout busy=%b required=0", busy_a);
    end
    checks++;
    if (steps_a != 6) begin
      failures++;
      $display("FAIL basic_steps got=%0d required=6", steps_a);
    end
    checks++;
    if (got_n_a != 6) begin
      failures++;
      $display("FAIL basic_words got=%0d required=6", got_n_a);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got_a[k] !== exp_word(k)) begin
        failures++;
        $display("FAIL basic_data[%0d] got=%h required=%h",
                 k, got_a[k], exp_word(k));
      end
    end
    checks++;
    if (dones_a != 1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL basic_done dones=%0d busy=%b required=1 0",
               dones_a, busy_a);
    end
    checks++;
    if (badm_a != 0 || badm_b != 0) begin
      failures++;
      $display("FAIL strobe_addr bad=%0d/%0d required=0/0",
               badm_a, badm_b);
    end
  endtask

  task automatic test_backpressure;
    bit to;
    out_ready = 1'b0;
    start_xfer(10);
    repeat (20) @(negedge clk);
    checks++;
    if (steps_a != 4 || steps_b != 4) begin
      failures++;
      $display("FAIL bp_stall_steps got=%0d/%0d required=4/4",
               steps_a, steps_b);
    end
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== exp_word(0)) begin
      failures++;
      $display("FAIL bp_head valid=%b data=%h required=1 %h",
               out_valid_a, out_data_a, exp_word(0));
    end
    checks++;
    if (stab_a != 0 || stab_b != 0) begin
      failures++;
      $display("FAIL bp_stable viol=%0d/%0d required=0/0",
               stab_a, stab_b);
    end
    out_ready = 1'b1;
    wait_idle(200, to);
    checks++;
    if (to || steps_a != 10 || dones_a != 1) begin
      failures++;
      $display("FAIL bp_finish to=%0d steps=%0d dones=%0d required=0 10 1",
               to, steps_a, dones_a);
    end
    checks++;
    if (got_n_a != 10 || got_n_b != 10) begin
      failures++;
      $display("FAIL bp_words got=%0d/%0d required=10/10",
               got_n_a, got_n_b);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (got_a[k] !== exp_word(k) || got_b[k] !== exp_word(k)) begin
        failures++;
        $display("FAIL bp_data[%0d] got=%h/%h required=%h",
                 k, got_a[k], got_b[k], exp_word(k));
      end
    end
  endtask

  task automatic test_zero;
    int lat = -1;
    out_ready = 1'b1;
    start_xfer(0);
    for (int i = 1; i <= 6; i++) begin
      if (done_a && lat < 0) lat = i;
      @(negedge clk);
    end
    checks++;
    if (lat < 1 || lat > 3) begin
      failures++;
      $display("FAIL zero_done_latency got=%0d required=1..3", lat);
    end
    checks++;
    if (steps_a != 0 || steps_b != 0) begin
      failures++;
      $display("FAIL zero_steps got=%0d/%0d required=0/0",
               steps_a, steps_b);
    end
    checks++;
    if (dones_a != 1 || dones_b != 1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL zero_done dones=%0d/%0d busy=%b required=1/1 0",
               dones_a, dones_b, busy_a);
    end
  endtask

  task automatic test_restart;
    bit to;
    out_ready = 1'b1;
    start_xfer(5);
    repeat (2) begin
      total_count = 16'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end
    wait_idle(100, to);
    checks++;
    if (to || steps_a != 5 || got_n_a != 5 || dones_a != 1) begin
      failures++;
      $display("FAIL restart to=%0d steps=%0d words=%0d dones=%0d required=0 5 5 1",
               to, steps_a, got_n_a, dones_a);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got_a[k] !== exp_word(k)) begin
        failures++;
        $display("FAIL restart_data[%0d] got=%h required=%h",
                 k, got_a[k], exp_word(k));
      end
    end
  endtask

  task automatic test_midreset;
    bit to = 1'b1;
    logic [4:0] va;
    out_ready = 1'b1;
    start_xfer(8);
    for (int i = 0; i < 50; i++) begin
      if (steps_a >= 3) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (to) begin
      failures++;
      $display("FAIL midreset_issue steps=%0d required=3", steps_a);
    end
    rst_n = 1'b0; mon_clr = 1'b1;
    @(negedge clk);
    va = {step_a, rd_en_a, out_valid_a, busy_a, done_a};
    checks++;
    if (va !== 5'b0) begin
      failures++;
      $display("FAIL midreset_outs outs=%b required=00000", va);
    end
    rst_n = 1'b1; mon_clr = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (got_n_a != 0 || got_n_b != 0 || steps_a != 0 || dones_a != 0) begin
      failures++;
      $display("FAIL midreset_stale words=%0d/%0d steps=%0d dones=%0d required=0",
               got_n_a, got_n_b, steps_a, dones_a);
    end
    start_xfer(2);
    wait_idle(100, to);
    checks++;
    if (to || got_n_a != 2 || dones_a != 1) begin
      failures++;
      $display("FAIL midreset_restart to=%0d words=%0d dones=%0d required=0 2 1",
               to, got_n_a, dones_a);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_a[k] !== exp_word(k)) begin
        failures++;
        $display("FAIL midreset_data[%0d] got=%h required=%h",
                 k, got_a[k], exp_word(k));
      end
    end
  endtask

  task automatic test_lat3_toggle;
    bit to = 1'b1;
    out_ready = 1'b1;
    start_xfer(20);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      out_ready = ~out_ready;
      if (!busy_a && !busy_b) begin
        to = 1'b0;
        break;
      end
    end
    out_ready = 1'b1;
    checks++;
    if (to || got_n_b != 20 || dones_b != 1) begin
      failures++;
      $display("FAIL lat3_finish to=%0d words=%0d dones=%0d required=0 20 1",
               to, got_n_b, dones_b);
    end
    checks++;
    if (maxo_b > 4 || maxo_a > 4) begin
      failures++;
      $display("FAIL lat3_overflow outstanding=%0d/%0d required<=4",
               maxo_a, maxo_b);
    end
    checks++;
    if (stab_b != 0 || got_n_a != 20) begin
      failures++;
      $display("FAIL lat3_misc viol=%0d words_a=%0d required=0 20",
               stab_b, got_n_a);
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (got_b[k] !== exp_word(k) || got_a[k] !== exp_word(k)) begin
        failures++;
        $display("FAIL lat3_data[%0d] got=%h/%h required=%h",
                 k, got_a[k], got_b[k], exp_word(k));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; total_count = '0;
    out_ready = 1'b0; gen_load = 1'b1; mon_clr = 1'b1;
    gen_base = '0; gen_stride = 16'd1;
    @(negedge clk);
    gen_load = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_restart();
    test_midreset();
    test_lat3_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
